bias_loader: RTL
================

BIAS_LOADER -- requirements
Module: bias_loader

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, bit width of one bias word.
REQ-002 SHALL have parameter PE_NUM, default 8, words packed per bias row (one per PE lane).
REQ-003 SHALL have parameter AWIDTH, default 5, bias memory row address width.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  single-cycle load request.
REQ-007 SHALL have port cfg_rows  input  AWIDTH+1  number of rows to load, sampled on accepted start.
REQ-008 SHALL have port abort  input  1  synchronous cancel of the current load.
REQ-009 SHALL have port s_data  input  DWIDTH  incoming bias word, signed two's complement.
REQ-010 SHALL have port s_valid  input  1  s_data valid.
REQ-011 SHALL have port s_ready  output  1  loader accepts s_data this cycle.
REQ-012 SHALL have port bias_we  output  1  bias memory write enable.
REQ-013 SHALL have port bias_waddr  output  AWIDTH  bias memory row address.
REQ-014 SHALL have port bias_wdata  output  PE_NUM*DWIDTH  packed bias row.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port done  output  1  single-cycle completion pulse.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, WRITE, DONE; all outputs registered.
REQ-018 IDLE: start=1 accepted; latch rows = min(cfg_rows, 2^AWIDTH); row=0, lane=0; next state LOAD, or DONE if latched rows=0.
REQ-019 start outside IDLE SHALL be ignored.
REQ-020 LOAD: s_ready=1; word transferred only when s_valid&&s_ready; s_valid low stalls with no state change.
REQ-021 Transferred word SHALL be stored in lane slice [lane*DWIDTH +: DWIDTH]; first word of a row goes to lane 0 (LSBs).
REQ-022 Transfer with lane=PE_NUM-1 SHALL go to WRITE with lane reset to 0; otherwise lane increments.
REQ-023 WRITE: s_ready=0; bias_we=1 for exactly one cycle, bias_waddr=row, bias_wdata=full packed row.
REQ-024 After WRITE: if row=rows-1 go DONE, else row increments and state returns to LOAD.
REQ-025 DONE: done=1 for one cycle, then IDLE; busy low from the IDLE cycle.
REQ-026 Row throughput SHALL be PE_NUM+1 cycles minimum with s_valid held high.
REQ-027 s_ready SHALL be 1 for the first time in the cycle after start is accepted.
REQ-028 abort=1 in LOAD or WRITE SHALL return to IDLE next cycle; no bias_we that cycle, partial row discarded, no done.
REQ-029 abort has priority over s_valid transfer and over WRITE in the same cycle.
REQ-030 bias_waddr SHALL never exceed 2^AWIDTH-1; rows clamped per REQ-018.
REQ-031 bias_wdata SHALL hold its last value when bias_we=0.

Reset
REQ-032 rst_n low SHALL force IDLE asynchronously; s_ready, bias_we, busy, done = 0; bias_waddr=0; bias_wdata=0; lane/row counters=0.
REQ-033 Reset mid-load SHALL discard the partial row; no write issued after release until a new start.

Verification
REQ-034 start, cfg_rows=2, 16 words 0x0001..0x0010 with s_valid continuous -> writes addr0 wdata lanes 0..7 = 0x0001..0x0008, addr1 = 0x0009..0x0010; done on cycle 2*(8+1)+2 after start; busy low after.
REQ-035 s_valid toggled 1/0 every cycle, cfg_rows=1 -> identical wdata to continuous case, write delayed to 8 handshakes; no extra writes.
REQ-036 cfg_rows=0 -> no bias_we, done pulse 2 cycles after start; cfg_rows=40 with AWIDTH=5 -> exactly 32 writes, last addr 31.
REQ-037 abort asserted after 5 words of row 1 (cfg_rows=3) -> one write (addr0) only, no done, IDLE next cycle; following start reloads from addr0.
REQ-038 rst_n pulled low asynchronously during WRITE -> bias_we drops immediately, all outputs 0, no further writes after release.
REQ-039 start asserted while busy -> ignored; cfg_rows change mid-load has no effect on row count.

Source files
------------

// File: rtl/bias_loader.sv
// rtl/bias_loader.sv - streams bias words into packed PE_NUM-lane rows and writes them to bias memory
module bias_loader #(
  parameter int DWIDTH = 16,
  parameter int PE_NUM = 8,
  parameter int AWIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [AWIDTH:0]          cfg_rows,
  input  logic                     abort,
  input  logic [DWIDTH-1:0]        s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic                     bias_we,
  output logic [AWIDTH-1:0]        bias_waddr,
  output logic [PE_NUM*DWIDTH-1:0] bias_wdata,
  output logic                     busy,
  output logic                     done
);

  localparam int LW = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
  localparam logic [AWIDTH:0] MAX_ROWS = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] ONE_ROW  = {{AWIDTH{1'b0}}, 1'b1};
  localparam logic [LW-1:0]   LAST_LANE = LW'(PE_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [LW-1:0]              lane_q, lane_d;
  logic [AWIDTH-1:0]          row_q, row_d;
  logic [AWIDTH:0]            rows_q, rows_d;
  logic [PE_NUM*DWIDTH-1:0]   row_buf_q, row_buf_d;
  logic [PE_NUM*DWIDTH-1:0]   wdata_q, wdata_d;
  logic [AWIDTH-1:0]          waddr_q, waddr_d;
  logic                       s_ready_q, s_ready_d;
  logic                       we_q, we_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic [AWIDTH:0]            clamped_rows;
  logic                       last_row;
  logic                       xfer;

  assign clamped_rows = (cfg_rows > MAX_ROWS) ? MAX_ROWS : cfg_rows;
  assign last_row     = ({1'b0, row_q} == (rows_q - ONE_ROW));
  // abort wins over a handshake in the same cycle, so the word is never taken
  assign xfer         = (state_q == S_LOAD) && s_valid && s_ready_q && !abort;

  // State register: FSM, counters, row buffer and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lane_q    <= '0;
      row_q     <= '0;
      rows_q    <= '0;
      row_buf_q <= '0;
      wdata_q   <= '0;
      waddr_q   <= '0;
      s_ready_q <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      row_q     <= row_d;
      rows_q    <= rows_d;
      row_buf_q <= row_buf_d;
      wdata_q   <= wdata_d;
      waddr_q   <= waddr_d;
      s_ready_q <= s_ready_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: row assembly, row sequencing, abort handling
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    row_d     = row_q;
    rows_d    = rows_q;
    row_buf_d = row_buf_q;
    wdata_d   = wdata_q;
    waddr_d   = waddr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_d  = clamped_rows;
          row_d   = '0;
          lane_d  = '0;
          state_d = (clamped_rows == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
          lane_d  = '0;
          row_d   = '0;
        end else if (xfer) begin
          for (int i = 0; i < PE_NUM; i++) begin
            if (LW'(i) == lane_q) begin
              row_buf_d[i*DWIDTH +: DWIDTH] = s_data;
            end
          end
          if (lane_q == LAST_LANE) begin
            // the completed row (including this word) is presented with the write
            lane_d  = '0;
            wdata_d = row_buf_d;
            waddr_d = row_q;
            state_d = S_WRITE;
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (abort) begin
          state_d = S_IDLE;
          lane_d  = '0;
          row_d   = '0;
        end else if (last_row) begin
          state_d = S_DONE;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output is a flop visible in its state
  always_comb begin
    s_ready_d = (state_d == S_LOAD);
    we_d      = (state_d == S_WRITE);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  assign s_ready    = s_ready_q;
  assign bias_we    = we_q;
  assign bias_waddr = waddr_q;
  assign bias_wdata = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
